// File: rtl/cordic_pkg.sv
// cordic_pkg: shared mode/state encodings and default address width for the cordic block
package cordic_pkg;
  localparam int CORDIC_ADDR_W = 5;
  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SWEEP  = 2'b01;
  localparam logic [1:0] MODE_CONT   = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} seq_state_t;
endpackage

// File: rtl/cordic_hold_timer.sv
// cordic_hold_timer: loadable ITER-1 down-counter; registered zero flag (clk, rst_n, load, dec, act -> zero)
module cordic_hold_timer #(
  parameter int ITER = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  input  logic act,
  output logic zero
);
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] RLD = CW'(ITER - 1);
  logic [CW-1:0] cnt, cnt_n;
  assign cnt_n = load ? RLD : (dec && cnt != '0) ? cnt - CW'(1) : cnt;
  // zero is registered from the next count so it is high exactly while the count is 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      zero <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      zero <= act && cnt_n == '0;
    end
endmodule

// File: rtl/cordic_addr_seq.sv
// cordic_addr_seq: sequences cordic ADDR over [first,last], holding each ITER cycles with a sample strobe
// ports: clk, rst_n, start, stop, mode, first_addr, last_addr -> ADDR, addr_valid, sample, busy, done, sweep_cnt
module cordic_addr_seq
  import cordic_pkg::*;
#(
  parameter int ADDR_W  = CORDIC_ADDR_W,
  parameter int ITER    = 16,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  first_addr,
  input  logic [ADDR_W-1:0]  last_addr,
  output logic [ADDR_W-1:0]  ADDR,
  output logic               addr_valid,
  output logic               sample,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_W-1:0] sweep_cnt
);
  seq_state_t st, st_n;
  logic [1:0] mode_q, mode_n;
  logic [ADDR_W-1:0] first_q, first_n, last_q, last_n, addr_n;
  logic [SWEEP_W-1:0] sw_n;
  logic load, dec, at_last;
  assign at_last = ADDR == last_q;
  cordic_hold_timer #(.ITER(ITER)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .dec(dec), .act(st_n == S_HOLD), .zero(sample)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= S_IDLE;
    else st <= st_n;
  // sample doubles as the end-of-hold flag: it is high exactly when the hold count is 0
  always_comb begin
    st_n    = st;
    mode_n  = mode_q;
    first_n = first_q;
    last_n  = last_q;
    addr_n  = ADDR;
    sw_n    = sweep_cnt;
    load    = 1'b0;
    dec     = 1'b0;
    case (st)
      S_IDLE:
        if (start && !stop) begin
          st_n    = S_HOLD;
          load    = 1'b1;
          mode_n  = (mode == 2'b11) ? MODE_SWEEP : mode;
          first_n = first_addr;
          last_n  = last_addr;
          addr_n  = first_addr;
          sw_n    = '0;
        end
      S_HOLD:
        if (stop) st_n = S_IDLE;
        else if (!sample) dec = 1'b1;
        else if (mode_q == MODE_SINGLE || (mode_q == MODE_SWEEP && at_last)) begin
          st_n = S_DONE;
          sw_n = (mode_q == MODE_SWEEP) ? SWEEP_W'(1) : sweep_cnt;
        end else begin
          load   = 1'b1;
          addr_n = (mode_q == MODE_CONT && at_last) ? first_q : ADDR + ADDR_W'(1);
          sw_n   = (mode_q == MODE_CONT && at_last && sweep_cnt != '1) ? sweep_cnt + SWEEP_W'(1) : sweep_cnt;
        end
      default: st_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q     <= MODE_SINGLE;
      first_q    <= '0;
      last_q     <= '0;
      ADDR       <= '0;
      sweep_cnt  <= '0;
      busy       <= 1'b0;
      addr_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      mode_q     <= mode_n;
      first_q    <= first_n;
      last_q     <= last_n;
      ADDR       <= addr_n;
      sweep_cnt  <= sw_n;
      busy       <= st_n == S_HOLD;
      addr_valid <= st_n == S_HOLD;
      done       <= st_n == S_DONE;
    end
endmodule

// File: tb/tb_cordic_addr_seq.sv
// tb_cordic_addr_seq: directed self-checking bench for cordic_addr_seq (ITER=16, ADDR_W=5)
module tb_cordic_addr_seq;
  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic stop = 0;
  logic [1:0] mode = 0;
  logic [4:0] first_addr = 0;
  logic [4:0] last_addr = 0;
  logic [4:0] ADDR;
  logic addr_valid, sample, busy, done;
  logic [7:0] sweep_cnt;
  int vecs = 0;
  int errs = 0;
  cordic_addr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .first_addr(first_addr), .last_addr(last_addr), .ADDR(ADDR), .addr_valid(addr_valid),
    .sample(sample), .busy(busy), .done(done), .sweep_cnt(sweep_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // start issued in cycle t; returns positioned at cycle t+1
  task automatic go(input logic [1:0] m, input logic [4:0] f, input logic [4:0] l);
    mode = m;
    first_addr = f;
    last_addr = l;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    vecs++; if ({ADDR, addr_valid, sample, busy, done, sweep_cnt} !== 17'd0) begin errs++; $display("FAIL reset_outs got %h want 0", {ADDR, addr_valid, sample, busy, done, sweep_cnt}); end
    rst_n = 1;
    tick();
    go(2'b00, 5'd9, 5'd9);
    tick();
    tick();
    vecs++; if (busy !== 1'b1 || ADDR !== 5'd9) begin errs++; $display("FAIL pre_async busy=%b addr=%0d want 1/9", busy, ADDR); end
    #3 rst_n = 0;
    #1;
    vecs++; if (busy !== 1'b0 || addr_valid !== 1'b0 || ADDR !== 5'd0) begin errs++; $display("FAIL async_rst busy=%b av=%b addr=%0d want 0/0/0", busy, addr_valid, ADDR); end
    for (int i = 0; i < 20; i++) begin
      tick();
      vecs++; if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL async_no_done done=%b busy=%b want 0/0", done, busy); end
    end
    rst_n = 1;
    tick();
  endtask
  task automatic test_single();
    int ns = 0;
    go(2'b00, 5'd1, 5'd7);
    vecs++; if (ADDR !== 5'd1 || busy !== 1'b1 || addr_valid !== 1'b1) begin errs++; $display("FAIL single_t1 addr=%0d busy=%b av=%b want 1/1/1", ADDR, busy, addr_valid); end
    for (int k = 1; k <= 16; k++) begin
      vecs++; if (sample !== (k == 16)) begin errs++; $display("FAIL single_sample k=%0d got %b want %b", k, sample, k == 16); end
      ns += sample;
      if (k < 16) tick();
    end
    tick();
    vecs++; if (done !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0 || ADDR !== 5'd1 || sweep_cnt !== 8'd0) begin errs++; $display("FAIL single_done done=%b busy=%b av=%b addr=%0d sw=%0d want 1/0/0/1/0", done, busy, addr_valid, ADDR, sweep_cnt); end
    tick();
    vecs++; if (done !== 1'b0 || ADDR !== 5'd1) begin errs++; $display("FAIL single_after done=%b addr=%0d want 0/1", done, ADDR); end
    vecs++; if (ns !== 1) begin errs++; $display("FAIL single_nsamp got %0d want 1", ns); end
  endtask
  task automatic run_sweep(input logic [1:0] m, input logic [4:0] f, input logic [4:0] l, input int n, input string nm);
    int ns = 0;
    logic [4:0] ea;
    go(m, f, l);
    for (int k = 1; k <= 16 * n; k++) begin
      ea = f + 5'((k - 1) / 16);
      vecs++; if (ADDR !== ea || sample !== (k % 16 == 0) || busy !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL %s_trace k=%0d addr=%0d smp=%b busy=%b done=%b want %0d/%b/1/0", nm, k, ADDR, sample, busy, done, ea, k % 16 == 0); end
      ns += sample;
      tick();
    end
    vecs++; if (done !== 1'b1 || busy !== 1'b0 || sweep_cnt !== 8'd1 || ADDR !== l) begin errs++; $display("FAIL %s_done done=%b busy=%b sw=%0d addr=%0d want 1/0/1/%0d", nm, done, busy, sweep_cnt, ADDR, l); end
    vecs++; if (ns !== n) begin errs++; $display("FAIL %s_nsamp got %0d want %0d", nm, ns, n); end
    tick();
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL %s_done_pulse got %b want 0", nm, done); end
  endtask
  task automatic test_sweep();
    run_sweep(2'b01, 5'd2, 5'd5, 4, "sweep");
  endtask
  task automatic test_wrap();
    run_sweep(2'b01, 5'd30, 5'd1, 4, "wrap");
  endtask
  task automatic test_mode11();
    run_sweep(2'b11, 5'd7, 5'd8, 2, "mode11");
  endtask
  task automatic test_continuous();
    logic [4:0] ea;
    logic [7:0] es;
    go(2'b10, 5'd0, 5'd3);
    for (int k = 1; k <= 321; k++) begin
      ea = 5'(((k - 1) / 16) % 4);
      es = 8'((k - 1) / 64);
      vecs++; if (ADDR !== ea || sample !== (k % 16 == 0) || sweep_cnt !== es || done !== 1'b0) begin errs++; $display("FAIL cont_trace k=%0d addr=%0d smp=%b sw=%0d done=%b want %0d/%b/%0d/0", k, ADDR, sample, sweep_cnt, done, ea, k % 16 == 0, es); end
      if (k < 321) tick();
    end
    stop = 1;
    tick();
    stop = 0;
    vecs++; if (busy !== 1'b0 || addr_valid !== 1'b0 || done !== 1'b0 || sample !== 1'b0 || sweep_cnt !== 8'd5 || ADDR !== 5'd0) begin errs++; $display("FAIL cont_stop busy=%b av=%b done=%b smp=%b sw=%0d addr=%0d want 0/0/0/0/5/0", busy, addr_valid, done, sample, sweep_cnt, ADDR); end
    tick();
    vecs++; if (done !== 1'b0 || sweep_cnt !== 8'd5) begin errs++; $display("FAIL cont_after done=%b sw=%0d want 0/5", done, sweep_cnt); end
  endtask
  task automatic test_abort();
    int ns = 0;
    go(2'b01, 5'd10, 5'd12);
    for (int k = 1; k < 5; k++) tick();
    stop = 1;
    tick();
    stop = 0;
    vecs++; if (busy !== 1'b0 || addr_valid !== 1'b0 || ADDR !== 5'd10) begin errs++; $display("FAIL abort_mid busy=%b av=%b addr=%0d want 0/0/10", busy, addr_valid, ADDR); end
    for (int k = 0; k < 20; k++) begin
      ns += sample + done;
      tick();
    end
    vecs++; if (ns !== 0) begin errs++; $display("FAIL abort_quiet sample+done count %0d want 0", ns); end
    go(2'b01, 5'd10, 5'd12);
    for (int k = 1; k < 16; k++) tick();
    vecs++; if (sample !== 1'b1) begin errs++; $display("FAIL abort_edge_smp got %b want 1", sample); end
    stop = 1;
    tick();
    stop = 0;
    vecs++; if (busy !== 1'b0 || sample !== 1'b0 || done !== 1'b0 || ADDR !== 5'd10) begin errs++; $display("FAIL abort_edge busy=%b smp=%b done=%b addr=%0d want 0/0/0/10", busy, sample, done, ADDR); end
  endtask
  task automatic test_ignore();
    go(2'b00, 5'd4, 5'd4);
    tick();
    mode = 2'b01;
    first_addr = 5'd20;
    last_addr = 5'd22;
    start = 1;
    tick();
    start = 0;
    vecs++; if (ADDR !== 5'd4 || busy !== 1'b1) begin errs++; $display("FAIL ignore_start addr=%0d busy=%b want 4/1", ADDR, busy); end
    for (int k = 3; k < 17; k++) tick();
    vecs++; if (done !== 1'b1 || ADDR !== 5'd4 || sweep_cnt !== 8'd0) begin errs++; $display("FAIL ignore_done done=%b addr=%0d sw=%0d want 1/4/0", done, ADDR, sweep_cnt); end
    tick();
    first_addr = 5'd17;
    start = 1;
    stop = 1;
    tick();
    start = 0;
    stop = 0;
    tick();
    vecs++; if (busy !== 1'b0 || addr_valid !== 1'b0 || ADDR !== 5'd4 || done !== 1'b0) begin errs++; $display("FAIL start_stop_idle busy=%b av=%b addr=%0d done=%b want 0/0/4/0", busy, addr_valid, ADDR, done); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_wrap();
    test_mode11();
    test_continuous();
    test_abort();
    test_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
